// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host-side client and the PS/2 transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx_done,
      input  tx_error
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx_done,
      output tx_error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one framed
// command byte on device clock falls, then check the device ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic         clk,
   input  logic         rst_n,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);
   localparam int unsigned InhW = $clog2(INHIBIT_CYCLES) + 1;
   localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {StIdle, StInhibit, StReq, StSend, StWaitIdle} state_e;

   state_e          state_q, state_d;
   logic [1:0]      clk_sync_q, data_sync_q;
   logic            clk_prev_q;
   logic            clk_s, data_s, fall, timeout;
   // frame bit 0 is the start bit, so the fall count indexes the bit on the line
   logic [10:0]     frame_q, frame_d;
   logic [3:0]      bit_cnt_q, bit_cnt_d;
   logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
   logic [ToW-1:0]  to_cnt_q, to_cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         state_q     <= StIdle;
         frame_q     <= '0;
         bit_cnt_q   <= '0;
         inh_cnt_q   <= '0;
         to_cnt_q    <= '0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
         data_sync_q <= {data_sync_q[0], ps2_data_in};
         clk_prev_q  <= clk_sync_q[1];
         state_q     <= state_d;
         frame_q     <= frame_d;
         bit_cnt_q   <= bit_cnt_d;
         inh_cnt_q   <= inh_cnt_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   assign clk_s   = clk_sync_q[1];
   assign data_s  = data_sync_q[1];
   assign fall    = clk_prev_q & ~clk_s;
   assign timeout = (to_cnt_q == ToW'(TIMEOUT_CYCLES));

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      bit_cnt_d   = bit_cnt_q;
      inh_cnt_d   = inh_cnt_q;
      to_cnt_d    = to_cnt_q;
      tx.tx_ready = 1'b0;
      tx.tx_done  = 1'b0;
      tx.tx_error = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;

      unique case (state_q)
         StIdle: begin
            tx.tx_ready = 1'b1;
            if (tx.tx_valid) begin
               frame_d   = {1'b1, ~^tx.tx_data, tx.tx_data, 1'b0};
               bit_cnt_d = '0;
               inh_cnt_d = '0;
               to_cnt_d  = '0;
               state_d   = StInhibit;
            end
         end

         StInhibit: begin
            ps2_clk_oe = 1'b1;
            if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
               state_d = StReq;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end

         StReq: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            to_cnt_d    = '0;
            state_d     = StSend;
         end

         StSend: begin
            ps2_data_oe = ~frame_q[bit_cnt_q];
            // a fall in the timeout cycle still counts as device activity
            if (fall) begin
               to_cnt_d = '0;
               if (bit_cnt_q == 4'd10) begin
                  if (!data_s) begin
                     tx.tx_done = 1'b1;
                     state_d    = StWaitIdle;
                  end else begin
                     tx.tx_error = 1'b1;
                     state_d     = StIdle;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (timeout) begin
               ps2_data_oe = 1'b0;
               tx.tx_error = 1'b1;
               state_d     = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         StWaitIdle: begin
            if (clk_s && data_s) begin
               state_d = StIdle;
            end else if (fall) begin
               to_cnt_d = '0;
            end else if (timeout) begin
               tx.tx_error = 1'b1;
               state_d     = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a wired-AND PS/2 device model clocks frames out of
// the transmitter, and each step compares against hand-computed frames and timings.
module tb_ps2_host_tx;
   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 100;
   localparam int          H   = 20;  // device clock half period in system cycles

   logic clk = 1'b0;
   logic rst_n;
   logic dev_clk, dev_data, glitch_en, glitch_clk;
   logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   int err_cnt     = 0;
   int both_cnt    = 0;
   int acc_cnt     = 0;
   logic err_prev  = 1'b0;

   ps2_host_tx_if tx ();

   assign ps2_clk_in  = glitch_en ? glitch_clk : (~ps2_clk_oe & dev_clk);
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx          (tx),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pulse accounting; a transfer that errors must leave the block ready next cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (err_prev) check("ready_after_error", 32'(tx.tx_ready), 32'd1);
         if (tx.tx_done) done_cnt++;
         if (tx.tx_error) err_cnt++;
         if (tx.tx_done && tx.tx_error) both_cnt++;
         if (tx.tx_valid && tx.tx_ready) acc_cnt++;
      end
      err_prev = tx.tx_error;
   end

   task automatic wait_ready(input string tag);
      int t = 0;
      while (tx.tx_ready !== 1'b1 && t < 200) begin
         cyc(1);
         t++;
      end
      check(tag, 32'(tx.tx_ready), 32'd1);
   endtask

   // Present a byte, check acceptance and the exact inhibit length, end one cycle into SEND.
   task automatic start_tx(input logic [7:0] d, input bit keep_valid, input bit glitch);
      int m;
      tx.tx_data  = d;
      tx.tx_valid = 1'b1;
      cyc(1);
      if (!keep_valid) tx.tx_valid = 1'b0;
      check("accept_ready_low", 32'(tx.tx_ready), 32'd0);
      check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
      check("accept_data_oe", 32'(ps2_data_oe), 32'd0);
      m = 0;
      while (ps2_data_oe !== 1'b1 && m < 200) begin
         if (glitch) begin
            glitch_en  = (m >= 2 && m < 14);
            glitch_clk = m[1];
         end
         cyc(1);
         m++;
      end
      glitch_en = 1'b0;
      check("inhibit_length", 32'(m), 32'(INH));
      check("req_clk_oe", 32'(ps2_clk_oe), 32'd1);
      cyc(1);
      check("send_clk_release", 32'(ps2_clk_oe), 32'd0);
      check("send_start_bit", 32'(ps2_data_oe), 32'd1);
   endtask

   // Device: samples the line at the end of each high phase, drives falls 1..nfalls.
   // With nfalls < 11 it returns right after the last fall, leaving the clock low.
   task automatic dev_frame(input bit ack, input int nfalls, input bit meddle,
                            output logic [10:0] bits);
      int t = 0;
      bits = '0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 1000) begin
         cyc(1);
         t++;
      end
      check("wait_send", 32'(t < 1000), 32'd1);
      if (t >= 1000) return;
      cyc(H);
      bits[0] = ps2_data_in;
      for (int n = 1; n <= nfalls; n++) begin
         if (n == 11 && ack) dev_data = 1'b0;
         dev_clk = 1'b0;
         if (n == nfalls && nfalls < 11) return;
         if (meddle && n == 5) begin
            tx.tx_data  = ~tx.tx_data;
            tx.tx_valid = 1'b1;
         end
         if (meddle && n == 8) tx.tx_valid = 1'b0;
         cyc(H);
         dev_clk = 1'b1;
         cyc(H);
         if (n <= 10) bits[n] = ps2_data_in;
      end
      dev_data = 1'b1;
   endtask

   initial begin
      logic [10:0] bits;
      int base_done, base_err, base_acc, n;
      logic oe_before;

      rst_n       = 1'b0;
      dev_clk     = 1'b1;
      dev_data    = 1'b1;
      glitch_en   = 1'b0;
      glitch_clk  = 1'b1;
      tx.tx_valid = 1'b0;
      tx.tx_data  = 8'h00;
      cyc(3);
      check("rst_ready", 32'(tx.tx_ready), 32'd1);
      check("rst_done", 32'(tx.tx_done), 32'd0);
      check("rst_error", 32'(tx.tx_error), 32'd0);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      rst_n = 1'b1;
      cyc(2);

      // 0xED with ACK: parity 1
      start_tx(8'hED, 1'b0, 1'b0);
      dev_frame(1'b1, 11, 1'b0, bits);
      check("frame_ed", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
      check("ed_ready_until_idle", 32'(tx.tx_ready), 32'd0);
      wait_ready("ed_ready_back");
      check("ed_done_count", 32'(done_cnt), 32'd1);
      check("ed_error_count", 32'(err_cnt), 32'd0);

      // 0x01 then 0xFF back-to-back with valid held: parities 0 and 1
      base_acc = acc_cnt;
      start_tx(8'h01, 1'b1, 1'b0);
      tx.tx_data = 8'hFF;
      dev_frame(1'b1, 11, 1'b0, bits);
      check("frame_01", 32'(bits), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
      check("b2b_single_accept", 32'(acc_cnt - base_acc), 32'd1);
      n = 0;
      while (acc_cnt - base_acc < 2 && n < 50) begin
         cyc(1);
         n++;
      end
      tx.tx_valid = 1'b0;
      check("b2b_second_accept", 32'(acc_cnt - base_acc), 32'd2);
      dev_frame(1'b1, 11, 1'b0, bits);
      check("frame_ff", 32'(bits), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
      wait_ready("ff_ready_back");
      check("b2b_done_count", 32'(done_cnt), 32'd3);

      // No ACK: error pulse only
      base_done = done_cnt;
      base_err  = err_cnt;
      start_tx(8'h5A, 1'b0, 1'b0);
      dev_frame(1'b0, 11, 1'b0, bits);
      check("frame_5a", 32'(bits), 32'({1'b1, 1'b1, 8'h5A, 1'b0}));
      check("noack_error_count", 32'(err_cnt - base_err), 32'd1);
      check("noack_done_count", 32'(done_cnt - base_done), 32'd0);
      check("noack_ready", 32'(tx.tx_ready), 32'd1);

      // Device stalls after the 4th fall. Pin low -> fall consumed 3 edges later,
      // then TMO counts to timeout: error visible after edge 3 + TMO.
      base_err = err_cnt;
      start_tx(8'h00, 1'b0, 1'b0);
      dev_frame(1'b1, 4, 1'b0, bits);
      n = 0;
      oe_before = 1'b0;
      while (tx.tx_error !== 1'b1 && n < 300) begin
         oe_before = ps2_data_oe;
         cyc(1);
         n++;
      end
      check("timeout_latency", 32'(n), 32'(TMO + 3));
      check("timeout_bit3_driven", 32'(oe_before), 32'd1);
      check("timeout_data_release", 32'(ps2_data_oe), 32'd0);
      check("timeout_clk_release", 32'(ps2_clk_oe), 32'd0);
      dev_clk = 1'b1;
      cyc(2);
      check("timeout_error_count", 32'(err_cnt - base_err), 32'd1);

      // Reset while D5 (0) is on the line
      base_done = done_cnt;
      base_err  = err_cnt;
      start_tx(8'h00, 1'b0, 1'b0);
      dev_frame(1'b1, 6, 1'b0, bits);
      cyc(4);
      check("pre_reset_d5", 32'(ps2_data_oe), 32'd1);
      rst_n = 1'b0;
      cyc(1);
      check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("midrst_ready", 32'(tx.tx_ready), 32'd1);
      dev_clk = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      check("midrst_no_pulses", 32'((done_cnt - base_done) + (err_cnt - base_err)), 32'd0);
      start_tx(8'hF4, 1'b0, 1'b0);
      dev_frame(1'b1, 11, 1'b0, bits);
      check("frame_f4", 32'(bits), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
      wait_ready("f4_ready_back");
      check("f4_done_count", 32'(done_cnt - base_done), 32'd1);

      // Falls during INHIBIT and input changes during SEND must not disturb the frame
      base_acc  = acc_cnt;
      base_done = done_cnt;
      start_tx(8'hA5, 1'b0, 1'b1);
      dev_frame(1'b1, 11, 1'b1, bits);
      check("frame_a5", 32'(bits), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
      wait_ready("a5_ready_back");
      check("a5_single_accept", 32'(acc_cnt - base_acc), 32'd1);
      check("a5_done_count", 32'(done_cnt - base_done), 32'd1);

      check("never_both_pulses", 32'(both_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
